// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream demultiplexer slice.
// Holds the default word and counter widths, plus the occupancy encoding
// used by each per-channel FIFO (EMPTY=0, ONE=1, FULL=2).
package stream_demux_pkg;

  localparam int N_DEFAULT  = 3;
  localparam int CW_DEFAULT = 8;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/stream_demux_chan_fifo.sv
// demux_chan_fifo: two-entry channel FIFO used once per output channel.
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   push        write push_data into the tail (ignored when full)
//   push_data   N-bit word to store
//   pop         consumer accepts the head (ignored when empty)
//   full        both entries occupied
//   valid       at least one entry occupied
//   data        head entry, forced to 0 while empty
module demux_chan_fifo
  import stream_demux_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [N-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         valid,
  output logic [N-1:0] data
);

  occ_t         occ;
  logic         wr_ptr;
  logic         rd_ptr;
  logic [N-1:0] mem [2];
  logic         push_ok;
  logic         pop_ok;

  // Guard the handshakes locally so a stray push into a full FIFO or a pop
  // from an empty one can never corrupt the pointers.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & valid;

  // Occupancy state machine plus storage. Pointers are single bits that wrap
  // naturally; a simultaneous push and pop in ONE keeps the occupancy while
  // the read pointer moves on to the freshly written word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ    <= OCC_EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case (occ)
        OCC_EMPTY: if (push_ok) occ <= OCC_ONE;
        OCC_ONE: begin
          if (push_ok && !pop_ok) occ <= OCC_FULL;
          else if (pop_ok && !push_ok) occ <= OCC_EMPTY;
        end
        OCC_FULL: if (pop_ok) occ <= OCC_ONE;
        default: occ <= OCC_EMPTY;
      endcase
    end
  end

  // Status and head word come straight from registered state, so there is
  // no combinational path from the writer to the reader.
  assign full  = (occ == OCC_FULL);
  assign valid = (occ != OCC_EMPTY);
  assign data  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/stream_demux.sv
// stream_demux: 1:2 registered valid/ready stream demultiplexer.
// Each accepted input word is steered by in_sel into one of two 2-entry
// channel FIFOs; a stalled channel only blocks words routed to it.
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   in_valid/in_ready        input handshake
//   in_data, in_sel          input word and its route (0 -> ch0, 1 -> ch1)
//   outK_valid/outK_ready    channel K output handshake
//   outK_data                channel K head word (0 when empty)
//   cnt0, cnt1               wrapping counts of words delivered per channel
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_sel,
  output logic          out0_valid,
  input  logic          out0_ready,
  output logic [N-1:0]  out0_data,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [N-1:0]  out1_data,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);

  logic full0;
  logic full1;
  logic accept;
  logic push0;
  logic push1;
  logic pop0;
  logic pop1;

  // Readiness depends only on the route bit and registered fullness; the
  // downstream ready signals deliberately play no part, so a full channel
  // refuses a word even in the cycle it is being drained.
  assign in_ready = ~rst & ~(in_sel ? full1 : full0);
  assign accept   = in_valid & in_ready;
  assign push0    = accept & ~in_sel;
  assign push1    = accept & in_sel;
  assign pop0     = out0_valid & out0_ready;
  assign pop1     = out1_valid & out1_ready;

  demux_chan_fifo #(.N(N)) u_chan0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .push_data (in_data),
    .pop       (pop0),
    .full      (full0),
    .valid     (out0_valid),
    .data      (out0_data)
  );

  demux_chan_fifo #(.N(N)) u_chan1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .push_data (in_data),
    .pop       (pop1),
    .full      (full1),
    .valid     (out1_valid),
    .data      (out1_data)
  );

  // Delivered-word counters; each wraps independently and both may step in
  // the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (pop0) cnt0 <= cnt0 + 1'b1;
      if (pop1) cnt1 <= cnt1 + 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// Testbench for stream_demux: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model of the two channels.
module tb_stream_demux;

  localparam int N  = 3;
  localparam int CW = 3;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_sel;
  logic          out0_valid;
  logic          out0_ready;
  logic [N-1:0]  out0_data;
  logic          out1_valid;
  logic          out1_ready;
  logic [N-1:0]  out1_data;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;

  int checkCount;
  int failCount;

  // Reference model: one queue of words per channel plus delivered totals.
  logic [N-1:0] q0[$];
  logic [N-1:0] q1[$];
  int           mCnt0;
  int           mCnt1;
  logic         lastAccepted;

  stream_demux #(.N(N), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Compare every DUT output against what the model says right now.
  task automatic compareAll(input string phase);
    logic expReady;
    expReady = in_sel ? (q1.size() < 2) : (q0.size() < 2);
    checkOutput({phase, " in_ready"}, 8'(in_ready), 8'(expReady));
    checkOutput({phase, " out0_valid"}, 8'(out0_valid), 8'(q0.size() != 0));
    checkOutput({phase, " out0_data"}, 8'(out0_data), (q0.size() != 0) ? 8'(q0[0]) : 8'h0);
    checkOutput({phase, " out1_valid"}, 8'(out1_valid), 8'(q1.size() != 0));
    checkOutput({phase, " out1_data"}, 8'(out1_data), (q1.size() != 0) ? 8'(q1[0]) : 8'h0);
    checkOutput({phase, " cnt0"}, 8'(cnt0), 8'(mCnt0 % (1 << CW)));
    checkOutput({phase, " cnt1"}, 8'(cnt1), 8'(mCnt1 % (1 << CW)));
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs,
  // then advance the model by the handshakes completing at the rising edge.
  task automatic applyStimulus(input string phase, input logic v, input logic [N-1:0] d,
                               input logic s, input logic r0, input logic r1);
    logic acc;
    logic p0;
    logic p1;
    @(negedge clk);
    in_valid   = v;
    in_data    = d;
    in_sel     = s;
    out0_ready = r0;
    out1_ready = r1;
    #1;
    compareAll(phase);
    acc = v && (s ? (q1.size() < 2) : (q0.size() < 2));
    p0  = r0 && (q0.size() != 0);
    p1  = r1 && (q1.size() != 0);
    @(posedge clk);
    if (p0) begin
      void'(q0.pop_front());
      mCnt0++;
    end
    if (p1) begin
      void'(q1.pop_front());
      mCnt1++;
    end
    if (acc) begin
      if (s) q1.push_back(d);
      else   q0.push_back(d);
    end
    lastAccepted = acc;
  endtask

  task automatic clearModel();
    q0.delete();
    q1.delete();
    mCnt0 = 0;
    mCnt1 = 0;
    lastAccepted = 1'b0;
  endtask

  initial begin
    logic         pv;
    logic [N-1:0] pd;
    logic         ps;

    checkCount = 0;
    failCount  = 0;
    clearModel();

    // Reset with a word offered: nothing may be accepted or presented.
    rst        = 1'b1;
    in_valid   = 1'b1;
    in_data    = 3'b111;
    in_sel     = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    #12;
    checkOutput("reset in_ready", 8'(in_ready), 8'h0);
    checkOutput("reset out0_valid", 8'(out0_valid), 8'h0);
    checkOutput("reset out1_valid", 8'(out1_valid), 8'h0);
    checkOutput("reset cnt0", 8'(cnt0), 8'h0);
    checkOutput("reset cnt1", 8'(cnt1), 8'h0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("release in_ready", 8'(in_ready), 8'h1);

    // Routing and one-cycle latency.
    applyStimulus("route", 1'b1, 3'b101, 1'b0, 1'b1, 1'b1);
    applyStimulus("route", 1'b1, 3'b011, 1'b1, 1'b1, 1'b1);
    applyStimulus("route", 1'b0, 3'b000, 1'b0, 1'b1, 1'b1);
    applyStimulus("route", 1'b0, 3'b000, 1'b0, 1'b1, 1'b1);

    // Backpressure on ch0, ch1 keeps flowing, then full-channel push+pop.
    applyStimulus("bp", 1'b1, 3'd1, 1'b0, 1'b0, 1'b1);
    applyStimulus("bp", 1'b1, 3'd2, 1'b0, 1'b0, 1'b1);
    applyStimulus("bp", 1'b1, 3'd4, 1'b1, 1'b0, 1'b1);
    applyStimulus("bp", 1'b1, 3'd3, 1'b0, 1'b0, 1'b1);
    applyStimulus("fullpop", 1'b1, 3'd3, 1'b0, 1'b1, 1'b1);
    applyStimulus("fullpop", 1'b1, 3'd3, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus("drain", 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);

    // Counter wrap on ch1 with a 3-bit counter.
    for (int i = 0; i < 9; i++) applyStimulus("wrap", 1'b1, 3'(i), 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus("wrap", 1'b0, 3'd0, 1'b1, 1'b1, 1'b1);

    // Randomized traffic; a pending word is held until it is accepted.
    pv = 1'b0;
    pd = '0;
    ps = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!(pv && !lastAccepted)) begin
        pv = ($urandom_range(0, 3) != 0);
        pd = 3'($urandom);
        ps = 1'($urandom);
      end
      applyStimulus("rand", pv, pd, ps, ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));
    end

    // Mid-stream reset: ch0 ONE, ch1 FULL, then asynchronous clear.
    for (int i = 0; i < 4; i++) applyStimulus("prefill", 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus("prefill", 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus("prefill", 1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
    applyStimulus("prefill", 1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    compareAll("prereset");
    #2;
    rst = 1'b1;
    #1;
    clearModel();
    checkOutput("midreset in_ready", 8'(in_ready), 8'h0);
    checkOutput("midreset out0_valid", 8'(out0_valid), 8'h0);
    checkOutput("midreset out1_valid", 8'(out1_valid), 8'h0);
    checkOutput("midreset cnt0", 8'(cnt0), 8'h0);
    checkOutput("midreset cnt1", 8'(cnt1), 8'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("postreset", 1'b1, 3'b110, 1'b1, 1'b0, 1'b1);
    #1;
    checkOutput("postreset first word", 8'(out1_data), 8'h6);
    applyStimulus("postreset", 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
    applyStimulus("postreset", 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
